uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_sender` instance between `NUM_REQ` byte-producing requesters. Each requester presents a byte with a request line. The arbiter picks a winner and latches its byte. It then drives the sender's `send`/`data` and tracks the sender's `busy` to know when the line is free again. It sits directly in front of the sender's inputs. An optional lock mode keeps one requester's multi-byte packet contiguous on the line.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `IDX_W`, `$clog2(NUM_REQ)`, width of requester index (derived, not overridden).

- `clk`  in  1  system clock, same clock as the `uart_sender`.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req`  in  NUM_REQ  per-requester byte request, level.
- `req_data`  in  NUM_REQ*8  requester i byte at bits [8i+7:8i].
- `ack`  out  NUM_REQ  one-cycle pulse: requester's byte taken.
- `lock`  in  NUM_REQ  packet lock. Present only with `UART_ARB_LOCK_EN`.
- `tx_send`  out  1  to sender `send`.
- `tx_data`  out  8  to sender `data`.
- `tx_busy`  in  1  from sender `busy`.
- `owner`  out  IDX_W  index of the current or last granted requester.
- `active`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - If any `req` bit is set, pick winner `w` round-robin, starting the search at `last+1` and wrapping at `NUM_REQ-1`→0.
  - Latch `req_data[w]` into `tx_data`, set `owner<=w`, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE, exactly one cycle:
  - `tx_send=1`, `ack[w]=1`.
  - Go to WAIT_START.
- WAIT_START: wait for `tx_busy==1`, then go to WAIT_DONE. `tx_send` is already low here.
- WAIT_DONE:
  - Wait for `tx_busy==0`, then set `last<=w` and go to IDLE.
- After `ack`, the requester may drop `req` or present its next byte. The arbiter re-samples `req`/`req_data` only in IDLE.
- Changes to `req_data[w]` after the latch do not affect the byte in flight.
- `tx_data` holds its value from latch until the next latch.
- The rotating pointer `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- Simultaneous requests are resolved purely by the pointer. No requester waits more than `NUM_REQ-1` bytes of other traffic (lock mode excepted).
- A `req` bit dropped before IDLE samples it is simply not granted. There is no penalty and no pointer change.
- Reset mid-operation:
  - State returns to IDLE.
  - `tx_send=0`, `ack=0`, `tx_data=0`, `owner=0`, `active=0`, `last=NUM_REQ-1`, lock state cleared.
  - A byte partially shifted by the sender is abandoned. The sender is reset from the same `rst`.

## Timing
- Request to `tx_send`: 2 cycles. Cycle 0 is IDLE sampling `req`; cycle 1 is ISSUE with `tx_send`/`ack` high.
- `tx_send` and `ack` are registered outputs, high for exactly one cycle each, in the same cycle.
- The sender raises `busy` 1 cycle after `send`. WAIT_START therefore normally lasts 1 cycle, but has no upper bound.
- Per-byte overhead beyond the sender's frame: 1 IDLE + 1 ISSUE + the WAIT_START cycles.
- Back-to-back bytes: the next `tx_send` comes 2 cycles after `tx_busy` falls.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - `lock[w]` is sampled in the ISSUE cycle into `locked`.
  - In IDLE with `locked` set, only `owner` may be granted. The arbiter waits in IDLE while `req[owner]==0 && lock[owner]==1`.
  - In IDLE, if `lock[owner]==0`, `locked` clears and normal round-robin resumes in that same cycle.
  - `last` still updates per byte.
- `UART_ARB_LOCK_EN` undefined:
  - The `lock` port is absent and no lock state exists.
  - Every byte is arbitrated independently.

## Test plan
- Reset, then `req=4'b0001`, `req_data[0]=8'hA5`:
  - `tx_send`/`ack[0]` pulse 2 cycles after `req`, with `tx_data=8'hA5` and `owner=0`.
  - The sender line shows frame 0xA5.
  - `active` drops 1 cycle after `tx_busy` falls.
- `req=4'b1111` held, each requester i sending byte 0x10+i for 8 grants:
  - Grant order is 0,1,2,3,0,1,2,3.
  - Exactly one `ack` per grant.
- Requester 2 holds `req` and changes `req_data` to 0xFF during WAIT_DONE: the in-flight frame still carries the latched value (0x33), and the new byte goes on the next grant.
- Assert `rst` low in WAIT_DONE mid-frame:
  - All outputs are 0 immediately.
  - `txd` is idle-high after reset.
  - The next request from requester 0 is granted first.
- With `UART_ARB_LOCK_EN` defined:
  - Requester 1 holds `lock` for 3 bytes while requester 0 requests continuously.
  - Line order is 1,1,1, then 0 in the IDLE cycle where `lock[1]` is seen low.
- With `UART_ARB_LOCK_EN` defined, requester 1 keeps `lock=1` with `req=0` for 20 cycles: no grant is issued to requester 0 until `lock[1]` drops.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_sender between NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to add the lock port that keeps one requester's packet contiguous.
module uart_tx_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDX_W-1:0]     owner,
  output logic                 active
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q;
  logic             rr_valid;
  logic [IDX_W-1:0] rr_idx;
  logic             hold;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
`ifdef UART_ARB_LOCK_EN
  logic             locked_q;
`endif

  // Search starts one past the last served requester and wraps to 0.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!rr_valid && req[cand_idx]) begin
        rr_valid = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
`ifdef UART_ARB_LOCK_EN
    hold = locked_q && lock[owner];
`else
    hold = 1'b0;
`endif
    if (hold) begin
      sel_valid = req[owner];
      sel_idx   = owner;
    end else begin
      sel_valid = rr_valid;
      sel_idx   = rr_idx;
    end
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel_onehot[i] = (sel_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (sel_valid) state_d = ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE:  if (!tx_busy) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // tx_send/ack are registered at the grant so they are high exactly during ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_send <= 1'b0;
      ack     <= '0;
      tx_data <= '0;
      owner   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      tx_send <= 1'b0;
      ack     <= '0;
      if (state_q == IDLE && sel_valid) begin
        tx_send <= 1'b1;
        ack     <= sel_onehot;
        tx_data <= req_data[{sel_idx, 3'b000} +: 8];
        owner   <= sel_idx;
      end
      if (state_q == WAIT_DONE && !tx_busy) last_q <= owner;
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      locked_q <= lock[owner];
    end else if (state_q == IDLE && !lock[owner]) begin
      locked_q <= 1'b0;
    end
  end
`endif

  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural sender + line decoder, rule-level grant model,
// and directed scenarios with literal expectations. Lock scenarios need UART_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_busy = 1'b0;
  logic [IDX_W-1:0]     owner;
  logic                 active;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   lock = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
`ifdef UART_ARB_LOCK_EN
    .lock(lock),
`endif
    .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .owner(owner), .active(active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sender: busy one cycle after send, 10 bits of CPB cycles each, LSB first.
  logic       txd = 1'b1;
  logic [9:0] sh;
  int         bit_n, cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy <= 1'b0; txd <= 1'b1; bit_n <= 0; cyc <= 0;
    end else if (!tx_busy) begin
      if (tx_send) begin
        sh <= {1'b1, tx_data, 1'b0}; tx_busy <= 1'b1; txd <= 1'b0; bit_n <= 0; cyc <= 0;
      end
    end else if (cyc == CPB - 1) begin
      cyc <= 0;
      if (bit_n == 9) begin tx_busy <= 1'b0; txd <= 1'b1; end
      else begin bit_n <= bit_n + 1; txd <= sh[bit_n + 1]; end
    end else begin
      cyc <= cyc + 1;
    end
  end

  // Line decoder: rebuilds bytes from txd alone; frames cut by reset are dropped.
  logic [7:0] line_exp[$];
  logic [7:0] line_log[$];
  bit frame_abort = 1'b0;
  always @(negedge rst) frame_abort = 1'b1;
  initial begin
    forever begin
      logic [7:0] b;
      @(negedge txd);
      frame_abort = 1'b0;
      repeat (CPB/2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(posedge clk);
      if (!frame_abort) begin
        chk("stop_bit", 32'(txd), 1);
        line_log.push_back(b);
        if (line_exp.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL line_unexpected: got byte %02h, expected no frame", b);
        end else begin
          chk("line_byte", 32'(b), 32'(line_exp.pop_front()));
        end
      end
    end
  end

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Model: the arbiter may only grant in a cycle following one where it was idle;
  // it is busy from the grant through the cycle after the sender's busy falls.
  int m_last = NUM_REQ - 1;
  bit m_idle_prev = 1'b0;
  bit busy_prev = 1'b0;
  logic [NUM_REQ-1:0]   req_prev;
  logic [NUM_REQ*8-1:0] data_prev;
  int grant_log[$];
  int ack_pulses = 0;
`ifdef UART_ARB_LOCK_EN
  bit m_locked = 1'b0;
  int m_owner = 0;
  logic [NUM_REQ-1:0] lock_prev;
`endif

  always @(negedge clk) begin
    int w;
    bit exp_active;
    if (!rst) begin
      chk("reset_outputs", 32'({ack, tx_send, tx_data, owner, active}), 0);
      m_last = NUM_REQ - 1; m_idle_prev = 1'b0; busy_prev = 1'b0;
      line_exp.delete();
`ifdef UART_ARB_LOCK_EN
      m_locked = 1'b0; m_owner = 0;
`endif
    end else begin
      w = -1;
      if (m_idle_prev) begin
`ifdef UART_ARB_LOCK_EN
        if (m_locked && lock_prev[m_owner]) w = req_prev[m_owner] ? m_owner : -1;
        else begin m_locked = 1'b0; w = rr_pick(req_prev, m_last); end
`else
        w = rr_pick(req_prev, m_last);
`endif
      end
      chk("tx_send", 32'(tx_send), 32'(w >= 0));
      if (tx_send) grant_log.push_back(int'(owner));
      if (ack != '0) ack_pulses++;
      if (w >= 0) begin
        chk("owner", 32'(owner), w);
        chk("ack", 32'(ack), 1 << w);
        chk("tx_data", 32'(tx_data), 32'(data_prev[w*8 +: 8]));
        line_exp.push_back(data_prev[w*8 +: 8]);
        m_last = w;
`ifdef UART_ARB_LOCK_EN
        m_locked = lock[w]; m_owner = w;
`endif
      end else begin
        chk("ack_quiet", 32'(ack), 0);
      end
      exp_active = (w >= 0) || tx_busy || busy_prev;
      chk("active", 32'(active), 32'(exp_active));
      m_idle_prev = !exp_active;
      busy_prev = tx_busy;
    end
    req_prev = req;
    data_prev = req_data;
`ifdef UART_ARB_LOCK_EN
    lock_prev = lock;
`endif
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grant_log.size() < target && n < budget) begin @(negedge clk); #1; n++; end
    if (grant_log.size() < target) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: got %0d grants, expected %0d", grant_log.size(), target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || tx_busy) && n < 300) begin step(); n++; end
    if (active || tx_busy) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: got active=%0b busy=%0b, expected both 0", active, tx_busy);
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0; req = '0;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (5) step();
    rst = 1'b1;
    step();
  endtask

  int base, lb, ab;
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single byte from requester 0.
    req = 4'b0001; req_data[7:0] = 8'hA5;
    @(negedge clk);
    chk("t1_send_cycle0", 32'(tx_send), 0);
    @(negedge clk);
    chk("t1_send_cycle1", 32'(tx_send), 1);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_owner", 32'(owner), 0);
    step();
    req = '0;
    wait_idle();
    chk("t1_line", 32'(line_log[line_log.size()-1]), 32'hA5);

    // All four requesting: strict rotation from requester 0.
    do_reset();
    base = grant_log.size(); lb = line_log.size(); ab = ack_pulses;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    wait_grants(base + 8, 8 * 60);
    step();
    req = '0;
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      chk("t2_order", 32'(grant_log[base + k]), exp_order[k]);
      chk("t2_line", 32'(line_log[lb + k]), 32'h10 + exp_order[k]);
    end
    chk("t2_ack_pulses", 32'(ack_pulses - ab), 8);

    // Byte changed while in flight does not disturb the latched one.
    do_reset();
    base = grant_log.size(); lb = line_log.size();
    req_data[23:16] = 8'h33;
    req = 4'b0100;
    wait_grants(base + 1, 60);
    repeat (10) step();
    req_data[23:16] = 8'hFF;
    wait_grants(base + 2, 80);
    step();
    req = '0;
    wait_idle();
    chk("t3_grant0", 32'(grant_log[base]), 2);
    chk("t3_grant1", 32'(grant_log[base + 1]), 2);
    chk("t3_line0", 32'(line_log[lb]), 32'h33);
    chk("t3_line1", 32'(line_log[lb + 1]), 32'hFF);

    // Reset in the middle of a frame.
    base = grant_log.size();
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    wait_grants(base + 1, 60);
    step();
    req = '0;
    repeat (15) step();
    rst = 1'b0;
    #1;
    chk("t4_async_reset", 32'({ack, tx_send, tx_data, owner, active}), 0);
    repeat (5) step();
    chk("t4_txd_idle", 32'(txd), 1);
    rst = 1'b1;
    repeat (50) step();
    base = grant_log.size(); lb = line_log.size();
    req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    req = 4'b1111;
    wait_grants(base + 1, 60);
    step();
    req = '0;
    wait_idle();
    chk("t4_first_after_reset", 32'(grant_log[base]), 0);
    chk("t4_line", 32'(line_log[lb]), 32'h40);
    chk("t4_line_count", 32'(line_log.size() - lb), 1);

`ifdef UART_ARB_LOCK_EN
    // Locked packet of three bytes from requester 1 while requester 0 waits.
    do_reset();
    base = grant_log.size();
    req_data = {8'h00, 8'h00, 8'h21, 8'h20};
    lock = 4'b0010; req = 4'b0010;
    wait_grants(base + 1, 60);
    step();
    req = 4'b0011;
    wait_grants(base + 3, 160);
    step();
    lock = '0; req = 4'b0001;
    wait_grants(base + 4, 80);
    step();
    req = '0;
    wait_idle();
    chk("t5_g0", 32'(grant_log[base]), 1);
    chk("t5_g1", 32'(grant_log[base + 1]), 1);
    chk("t5_g2", 32'(grant_log[base + 2]), 1);
    chk("t5_g3", 32'(grant_log[base + 3]), 0);

    // Lock held with no request blocks everybody else.
    do_reset();
    base = grant_log.size();
    lock = 4'b0010; req = 4'b0010;
    wait_grants(base + 1, 60);
    step();
    req = 4'b0001;
    wait_idle();
    repeat (20) step();
    chk("t6_blocked", 32'(grant_log.size()), 32'(base + 1));
    lock = '0;
    wait_grants(base + 2, 20);
    step();
    req = '0;
    wait_idle();
    chk("t6_after_unlock", 32'(grant_log[base + 1]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1);
  end

endmodule
